// File: rtl/x_cmd_des_pkg.sv
// Shared types and default sizing for the x_cmd_des command deserializer.
// Holds the opcode and FSM state encodings plus derived width helpers.
package x_cmd_des_pkg;

  localparam int CMD_W       = 8;
  localparam int SEL_W       = 5;
  localparam int LANE_W      = 5;
  localparam int DEF_WIDTH   = 64;
  localparam int DEF_NCH     = 4;
  localparam int DEF_TIMEOUT = 1023;
  localparam int DEF_IDX_W   = $clog2(DEF_WIDTH);
  localparam int DEF_LANES   = DEF_WIDTH / 8;
  localparam int DEF_DATA_W  = DEF_NCH * DEF_WIDTH;

  typedef enum logic [2:0] {
    OP_NOP       = 3'b000,
    OP_SEL       = 3'b001,
    OP_WRBIT     = 3'b010,
    OP_APPLY     = 3'b011,
    OP_APPLY_ALL = 3'b100,
    OP_CLR       = 3'b101,
    OP_WRBYTE    = 3'b110,
    OP_CLRERR    = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE          = 2'd0,
    ST_GET_IDX       = 2'd1,
    ST_GET_LANE_DATA = 2'd2
  } state_t;

  // Timeout counter width; a disabled timeout still gets a 1-bit counter.
  function automatic int tmo_w(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/x_cmd_des_if.sv
// Command byte stream in, applied channel words and status out.
// i_valid qualifies i_cmd; a byte is consumed on every rising edge with
// i_valid high and there is no ready/backpressure path.
interface x_cmd_des_if #(
  parameter int WIDTH = 64,
  parameter int NCH   = 4
);
  logic                 i_valid;
  logic [7:0]           i_cmd;
  logic [NCH*WIDTH-1:0] o_data;
  logic [NCH-1:0]       o_apply;
  logic                 o_err;
  logic                 o_busy;

  modport master (
    output i_valid, i_cmd,
    input  o_data, o_apply, o_err, o_busy
  );

  modport slave (
    input  i_valid, i_cmd,
    output o_data, o_apply, o_err, o_busy
  );
endinterface

// File: rtl/x_cmd_des_bank.sv
// One channel: shadow word edited by commands, applied word copied from the
// shadow on apply, and a registered one-cycle apply pulse.
module x_cmd_des_bank
  import x_cmd_des_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr_bit,
  input  logic [$clog2(WIDTH)-1:0] i_bit_idx,
  input  logic                     i_bit_val,
  input  logic                     i_wr_byte,
  input  logic [LANE_W-1:0]        i_lane,
  input  logic [7:0]               i_lane_data,
  input  logic                     i_clr,
  input  logic                     i_apply,
  output logic [WIDTH-1:0]         o_word,
  output logic                     o_apply
);

  localparam int LANES = WIDTH / 8;

  logic [WIDTH-1:0] shadow_q;

  // Lane select is a compare loop so an out-of-range lane can never slice past the word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow_q <= '0;
      o_word   <= '0;
      o_apply  <= 1'b0;
    end else begin
      if (i_clr) begin
        shadow_q <= '0;
      end else if (i_wr_bit) begin
        shadow_q[i_bit_idx] <= i_bit_val;
      end else if (i_wr_byte) begin
        for (int l = 0; l < LANES; l++) begin
          if (i_lane == LANE_W'(l)) shadow_q[l*8 +: 8] <= i_lane_data;
        end
      end
      o_apply <= i_apply;
      if (i_apply) o_word <= shadow_q;
    end
  end

endmodule

// File: rtl/x_cmd_des.sv
// Byte-serial command deserializer: decodes headers/operands, keeps channel
// selection, operand timeout and sticky error, and drives NCH channel banks.
module x_cmd_des
  import x_cmd_des_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NCH     = DEF_NCH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  x_cmd_des_if.slave  bus,
  output state_t      o_state
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int LANES = WIDTH / 8;
  localparam int TMO_W = tmo_w(TIMEOUT);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [4:0]        hdr_q, hdr_d;
  logic [TMO_W-1:0]  tmo_q;
  logic              err_q;
  logic              err_set, err_clr;
  logic              wr_bit, wr_byte, clr_sel, apply_sel, apply_all;
  logic              timeout_hit;
  opcode_t           op;
  logic [WIDTH-1:0]  word [NCH];
  logic [NCH-1:0]    apply_vec;

  assign op          = opcode_t'(bus.i_cmd[7:5]);
  assign timeout_hit = (TIMEOUT != 0) && (32'(tmo_q) == 32'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    hdr_d     = hdr_q;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    wr_bit    = 1'b0;
    wr_byte   = 1'b0;
    clr_sel   = 1'b0;
    apply_sel = 1'b0;
    apply_all = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_valid) begin
          hdr_d = bus.i_cmd[4:0];
          case (op)
            OP_SEL: begin
              if ({1'b0, bus.i_cmd[4:0]} < 6'(NCH)) sel_d = bus.i_cmd[4:0];
              else                                  err_set = 1'b1;
            end
            OP_WRBIT:     state_d   = ST_GET_IDX;
            OP_WRBYTE:    state_d   = ST_GET_LANE_DATA;
            OP_APPLY:     apply_sel = 1'b1;
            OP_APPLY_ALL: apply_all = 1'b1;
            OP_CLR:       clr_sel   = 1'b1;
            OP_CLRERR:    err_clr   = 1'b1;
            default:      ;
          endcase
        end
      end
      // Operand states take any byte value as data; only a timeout exits without one.
      ST_GET_IDX: begin
        if (bus.i_valid) begin
          state_d = ST_IDLE;
          if ({1'b0, bus.i_cmd} < 9'(WIDTH)) wr_bit  = 1'b1;
          else                               err_set = 1'b1;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
          err_set = 1'b1;
        end
      end
      ST_GET_LANE_DATA: begin
        if (bus.i_valid) begin
          state_d = ST_IDLE;
          if ({1'b0, hdr_q} < 6'(LANES)) wr_byte = 1'b1;
          else                           err_set = 1'b1;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
          err_set = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      hdr_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      hdr_q   <= hdr_d;
      if (bus.i_valid || state_d == ST_IDLE) tmo_q <= '0;
      else                                   tmo_q <= tmo_q + 1'b1;
      if (err_set)      err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_bank
    logic hit;
    assign hit = (sel_q == SEL_W'(c));

    x_cmd_des_bank #(.WIDTH(WIDTH)) u_bank (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_wr_bit    (wr_bit && hit),
      .i_bit_idx   (bus.i_cmd[IDX_W-1:0]),
      .i_bit_val   (hdr_q[0]),
      .i_wr_byte   (wr_byte && hit),
      .i_lane      (hdr_q),
      .i_lane_data (bus.i_cmd),
      .i_clr       (clr_sel && hit),
      .i_apply     (apply_all || (apply_sel && hit)),
      .o_word      (word[c]),
      .o_apply     (apply_vec[c])
    );
  end

  always_comb begin
    bus.o_data = '0;
    for (int c = 0; c < NCH; c++) bus.o_data[c*WIDTH +: WIDTH] = word[c];
  end

  assign bus.o_apply = apply_vec;
  assign bus.o_err   = err_q;
  assign bus.o_busy  = (state_q != ST_IDLE);
  assign o_state     = state_q;

endmodule

// File: tb/tb_x_cmd_des.sv
// Directed bench for x_cmd_des: byte driver, apply-pulse monitor against an
// expected queue, direct status checks, and a one-line report.
module tb_x_cmd_des;
  import x_cmd_des_pkg::*;

  localparam int WIDTH   = 64;
  localparam int NCH     = 4;
  localparam int TIMEOUT = 8;
  localparam int W       = NCH + NCH * WIDTH;

  logic   i_clk = 1'b0;
  logic   i_rst_n;
  state_t dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0]     exp_q[$];
  logic [W-1:0]     mon_exp;
  logic [WIDTH-1:0] exp_word [NCH];

  x_cmd_des_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

  x_cmd_des #(.WIDTH(WIDTH), .NCH(NCH), .TIMEOUT(TIMEOUT)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard helpers
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] packed_exp(input logic [NCH-1:0] mask);
    return {mask, exp_word[3], exp_word[2], exp_word[1], exp_word[0]};
  endfunction

  task automatic push_exp(input logic [NCH-1:0] mask);
    exp_q.push_back(packed_exp(mask));
  endtask

  // driver tasks
  task automatic send(input logic [7:0] b);
    @(posedge i_clk);
    #1;
    bus.i_valid = 1'b1;
    bus.i_cmd   = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
      bus.i_valid = 1'b0;
      bus.i_cmd   = 8'h00;
    end
  endtask

  // monitor: every apply pulse must match the head of the expected queue
  always @(negedge i_clk) begin
    if (i_rst_n === 1'b1 && bus.o_apply !== '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL apply_unexpected: got apply=%b data=%0h expected no pulse", bus.o_apply, bus.o_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("apply_pulse", {bus.o_apply, bus.o_data}, mon_exp);
      end
    end
  end

  initial begin
    bus.i_valid = 1'b0;
    bus.i_cmd   = 8'h00;
    i_rst_n     = 1'b0;
    for (int c = 0; c < NCH; c++) exp_word[c] = '0;

    // reset state
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_data",  W'(bus.o_data),  '0);
    check("rst_apply", W'(bus.o_apply), '0);
    check("rst_err",   W'(bus.o_err),   '0);
    check("rst_busy",  W'(bus.o_busy),  '0);
    check("rst_state", W'(dbg_state),   W'(ST_IDLE));
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // SEL 2, WRBIT bit 5 = 1, APPLY
    exp_word[2] = 64'h20;
    push_exp(4'b0100);
    send(8'h22); send(8'h41); send(8'h05); send(8'h60);
    idle(2);
    check("t1_hold", {bus.o_apply, bus.o_data}, packed_exp(4'b0000));

    // SEL 0, WRBYTE lane 7 = A5, APPLY back-to-back
    exp_word[0] = 64'hA500_0000_0000_0000;
    push_exp(4'b0001);
    send(8'h20); send(8'hC7); send(8'hA5); send(8'h60);
    idle(2);

    // bad SEL, bad bit index, CLRERR
    send(8'h25);
    idle(2);
    check("t3_sel_err", W'(bus.o_err), W'(1));
    send(8'h41); send(8'h40);
    idle(2);
    check("t3_idx_err",  W'(bus.o_err),  W'(1));
    check("t3_idx_busy", W'(bus.o_busy), '0);
    push_exp(4'b0001);
    send(8'h60);
    idle(2);
    send(8'hE0);
    idle(2);
    check("t3_clrerr", W'(bus.o_err), '0);

    // operand timeout after WRBIT header
    send(8'h41);
    idle(1);
    check("t4_busy_start", W'(bus.o_busy), W'(1));
    check("t4_state_idx",  W'(dbg_state),  W'(ST_GET_IDX));
    idle(TIMEOUT - 1);
    check("t4_busy_before", W'(bus.o_busy), W'(1));
    idle(1);
    check("t4_busy_after", W'(bus.o_busy), '0);
    check("t4_err",        W'(bus.o_err),  W'(1));
    push_exp(4'b0001);
    send(8'h60);
    idle(2);
    send(8'hE0);
    idle(1);
    check("t4_clrerr", W'(bus.o_err), '0);

    // distinct shadows on every channel, then APPLY_ALL
    for (int c = 0; c < NCH; c++) begin
      send(8'h20 | 8'(c));
      send(8'hA0);
      send(8'hC0 | 8'(c));
      send(8'(17 * (c + 1)));
    end
    send(8'h22); send(8'h41); send(8'h3F);
    idle(2);
    check("t5_shadow_hidden", {bus.o_apply, bus.o_data}, packed_exp(4'b0000));
    exp_word[0] = 64'h0000_0000_0000_0011;
    exp_word[1] = 64'h0000_0000_0000_2200;
    exp_word[2] = 64'h8000_0000_0033_0000;
    exp_word[3] = 64'h0000_0000_4400_0000;
    push_exp(4'b1111);
    send(8'h80);
    idle(2);

    // CLR leaves applied word alone; two APPLYs give two pulses
    send(8'h23); send(8'hA0);
    idle(2);
    check("t5_clr_hold", {bus.o_apply, bus.o_data}, packed_exp(4'b0000));
    exp_word[3] = '0;
    push_exp(4'b1000);
    push_exp(4'b1000);
    send(8'h60); send(8'h60);
    idle(2);

    // out-of-range lane discards the write
    send(8'hC8); send(8'h77);
    idle(2);
    check("t5_lane_err",  W'(bus.o_err),  W'(1));
    check("t5_lane_busy", W'(bus.o_busy), '0);
    push_exp(4'b1000);
    send(8'h60); send(8'h00);
    idle(2);

    // reset in the middle of a WRBYTE, with o_err set beforehand
    send(8'h25); send(8'h21); send(8'hC1);
    idle(1);
    check("t6_busy_pre", W'(bus.o_busy), W'(1));
    check("t6_err_pre",  W'(bus.o_err),  W'(1));
    #1;
    i_rst_n = 1'b0;
    #1;
    check("t6_rst_data",  W'(bus.o_data),  '0);
    check("t6_rst_apply", W'(bus.o_apply), '0);
    check("t6_rst_err",   W'(bus.o_err),   '0);
    check("t6_rst_busy",  W'(bus.o_busy),  '0);
    check("t6_rst_state", W'(dbg_state),   W'(ST_IDLE));
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int c = 0; c < NCH; c++) exp_word[c] = '0;
    push_exp(4'b0001);
    send(8'h60);
    idle(3);
    check("t6_busy_post", W'(bus.o_busy), '0);

    idle(4);
    check("exp_q_empty", W'(exp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
